// File: rtl/nbit_addsub_seq.sv
// rtl/nbit_addsub_seq.sv - chunked add/subtract unit with handshakes, flags and saturating modes
// Operands are processed W bits per cycle, LSB chunk first, through a registered carry chain.
module nbit_addsub_seq #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         borrow,
  output logic         overflow,
  output logic         zero
);

  localparam int NCHUNK = N / W;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  localparam logic [1:0] MODE_SUB  = 2'b00;
  localparam logic [1:0] MODE_ADD  = 2'b01;
  localparam logic [1:0] MODE_USAT = 2'b10;
  localparam logic [1:0] MODE_SSAT = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, b_q, acc_q;
  logic [1:0]     mode_q;
  logic [CW-1:0]  cnt_q;
  logic           carry_q;

  logic           sub;
  logic           accept;
  logic           last;
  logic [W-1:0]   a_chunk, b_chunk;
  logic [W:0]     sum;
  logic [N-1:0]   raw, fin;
  logic           bo_d, ov_raw, ov_d;

  assign sub       = (mode_q != MODE_ADD);
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && (state_q == IDLE);
  assign last      = (cnt_q == LAST);

  // One chunk of a + (~b for subtract) + carry; raw is the accumulated result including this chunk.
  always_comb begin
    a_chunk = a_q[int'(cnt_q)*W +: W];
    b_chunk = b_q[int'(cnt_q)*W +: W];
    if (sub) b_chunk = ~b_chunk;
    sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{W{1'b0}}, carry_q};
    raw = acc_q;
    raw[int'(cnt_q)*W +: W] = sum[W-1:0];
  end

  always_comb begin
    bo_d = sub ? ~sum[W] : sum[W];
    if (sub)
      ov_raw = (a_q[N-1] != b_q[N-1]) && (raw[N-1] != a_q[N-1]);
    else
      ov_raw = (a_q[N-1] == b_q[N-1]) && (raw[N-1] != a_q[N-1]);
    fin  = raw;
    ov_d = ov_raw;
    case (mode_q)
      MODE_USAT: begin
        ov_d = 1'b0;
        if (bo_d) fin = '0;
      end
      MODE_SSAT: begin
        if (ov_raw) fin = a_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
      MODE_SUB: ;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mode_q   <= MODE_SUB;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result   <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= a;
        b_q     <= b;
        mode_q  <= mode;
        acc_q   <= '0;
        cnt_q   <= '0;
        carry_q <= (mode != MODE_ADD);
      end
      if (state_q == BUSY) begin
        acc_q   <= raw;
        carry_q <= sum[W];
        cnt_q   <= cnt_q + 1'b1;
        // Visible outputs only move on the final chunk, never mid-operation.
        if (last) begin
          result   <= fin;
          borrow   <= bo_d;
          overflow <= ov_d;
          zero     <= (fin == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_nbit_addsub_seq.sv
// tb/tb_nbit_addsub_seq.sv - randomized self-checking bench for nbit_addsub_seq
// Instance 0 is N=8/W=4 (two chunks), instance 1 is N=8/W=8 (single chunk).
module tb_nbit_addsub_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a, b;
  logic [1:0] mode;
  logic       iv [2];
  logic       ordy [2];
  logic       ir_w [2];
  logic       ovld_w [2];
  logic [7:0] res_w [2];
  logic       bo_w [2];
  logic       ovf_w [2];
  logic       z_w [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] va [7] = '{8'h05, 8'h03, 8'h03, 8'hF0, 8'h70, 8'h80, 8'h7F};
  logic [7:0] vb [7] = '{8'h03, 8'h05, 8'h05, 8'h20, 8'h10, 8'h01, 8'hFF};
  logic [1:0] vm [7] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3};
  logic [7:0] vr [7] = '{8'h02, 8'hFE, 8'h00, 8'h10, 8'h80, 8'h80, 8'h7F};
  logic       vbo [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       vov [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       vz  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  nbit_addsub_seq #(.N(8), .W(4)) u_chunked (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir_w[0]), .a(a), .b(b), .mode(mode),
    .out_valid(ovld_w[0]), .out_ready(ordy[0]), .result(res_w[0]), .borrow(bo_w[0]),
    .overflow(ovf_w[0]), .zero(z_w[0])
  );

  nbit_addsub_seq #(.N(8), .W(8)) u_single (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir_w[1]), .a(a), .b(b), .mode(mode),
    .out_valid(ovld_w[1]), .out_ready(ordy[1]), .result(res_w[1]), .borrow(bo_w[1]),
    .overflow(ovf_w[1]), .zero(z_w[1])
  );

  // Reference: integer arithmetic on whole operands, returns {result, borrow, overflow, zero}.
  function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m);
    int ux, uy, sx, sy, full, sres;
    logic [7:0] r;
    logic bo, ov;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (m == 2'd1) begin
      full = ux + uy;
      bo   = (full > 255);
      sres = sx + sy;
    end else begin
      full = ux - uy;
      bo   = (ux < uy);
      sres = sx - sy;
    end
    r  = full[7:0];
    ov = (sres > 127) || (sres < -128);
    if (m == 2'd2) begin
      ov = 1'b0;
      if (bo) r = 8'h00;
    end
    if (m == 2'd3 && ov) r = (sx < 0) ? 8'h80 : 8'h7F;
    return {r, bo, ov, (r == 8'h00)};
  endfunction

  // Presents one operand set, scrambles inputs while busy, returns edges-to-out_valid (-1 on timeout).
  task automatic start_op(input int sel, input logic [7:0] xa, input logic [7:0] xb,
                          input logic [1:0] xm, output int lat);
    @(negedge clk);
    a = xa; b = xb; mode = xm; iv[sel] = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      #1;
      a = 8'($urandom); b = 8'($urandom); mode = 2'($urandom); iv[sel] = 1'($urandom);
      @(posedge clk);
      #1;
      if (ovld_w[sel]) begin
        lat = i;
        break;
      end
    end
    iv[sel] = 1'b0;
  endtask

  task automatic release_op(input int sel);
    @(negedge clk);
    ordy[sel] = 1'b1;
    @(posedge clk);
    #1;
    ordy[sel] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; iv[0] = 0; iv[1] = 0; ordy[0] = 0; ordy[1] = 0; a = 0; b = 0; mode = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_tests++;
      if (ir_w[s] !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready[%0d]: got %b want 0", s, ir_w[s]); end
      n_tests++;
      if (ovld_w[s] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid[%0d]: got %b want 0", s, ovld_w[s]); end
      n_tests++;
      if ({res_w[s], bo_w[s], ovf_w[s], z_w[s]} !== 11'd0) begin
        n_fail++; $display("FAIL reset_outputs[%0d]: got %h want 000", s, {res_w[s], bo_w[s], ovf_w[s], z_w[s]});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (ir_w[0] !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", ir_w[0]); end
  endtask

  task automatic test_vectors;
    int lat;
    for (int k = 0; k < 7; k++) begin
      start_op(0, va[k], vb[k], vm[k], lat);
      n_tests++;
      if (lat != 2) begin n_fail++; $display("FAIL vec%0d_latency: got %0d want 2", k, lat); end
      n_tests++;
      if (res_w[0] !== vr[k]) begin n_fail++; $display("FAIL vec%0d_result: got %h want %h", k, res_w[0], vr[k]); end
      n_tests++;
      if (bo_w[0] !== vbo[k]) begin n_fail++; $display("FAIL vec%0d_borrow: got %b want %b", k, bo_w[0], vbo[k]); end
      n_tests++;
      if (ovf_w[0] !== vov[k]) begin n_fail++; $display("FAIL vec%0d_overflow: got %b want %b", k, ovf_w[0], vov[k]); end
      n_tests++;
      if (z_w[0] !== vz[k]) begin n_fail++; $display("FAIL vec%0d_zero: got %b want %b", k, z_w[0], vz[k]); end
      release_op(0);
    end
  endtask

  task automatic test_random;
    int lat;
    logic [7:0] xa, xb;
    logic [1:0] xm;
    logic [10:0] exp_v;
    for (int k = 0; k < 80; k++) begin
      int sel;
      sel = (k % 4 == 3) ? 1 : 0;
      xa = 8'($urandom); xb = 8'($urandom); xm = 2'($urandom);
      if (k % 10 == 0) xb = xa;
      exp_v = model(xa, xb, xm);
      start_op(sel, xa, xb, xm, lat);
      n_tests++;
      if (lat != 2 - sel) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", k, lat, 2 - sel); end
      n_tests++;
      if ({res_w[sel], bo_w[sel], ovf_w[sel], z_w[sel]} !== exp_v) begin
        n_fail++;
        $display("FAIL rand%0d_outputs a=%h b=%h m=%0d: got %h want %h", k, xa, xb, xm,
                 {res_w[sel], bo_w[sel], ovf_w[sel], z_w[sel]}, exp_v);
      end
      release_op(sel);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [10:0] exp_v;
    exp_v = model(8'h3C, 8'hA5, 2'd3);
    start_op(0, 8'h3C, 8'hA5, 2'd3, lat);
    repeat (5) begin
      @(negedge clk);
      iv[0] = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      @(posedge clk);
      #1;
      n_tests++;
      if (ovld_w[0] !== 1'b1 || ir_w[0] !== 1'b0) begin
        n_fail++; $display("FAIL bp_handshake: got valid=%b ready=%b want 1/0", ovld_w[0], ir_w[0]);
      end
      n_tests++;
      if ({res_w[0], bo_w[0], ovf_w[0], z_w[0]} !== exp_v) begin
        n_fail++; $display("FAIL bp_hold: got %h want %h", {res_w[0], bo_w[0], ovf_w[0], z_w[0]}, exp_v);
      end
    end
    iv[0] = 1'b0;
    release_op(0);
    n_tests++;
    if (ovld_w[0] !== 1'b0 || ir_w[0] !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", ovld_w[0], ir_w[0]);
    end
  endtask

  task automatic test_isolation;
    int lat;
    start_op(0, 8'h05, 8'h03, 2'd0, lat);
    n_tests++;
    if (res_w[0] !== 8'h02) begin n_fail++; $display("FAIL isolation_result: got %h want 02", res_w[0]); end
    release_op(0);
  endtask

  task automatic test_reset_busy;
    @(negedge clk);
    a = 8'h40; b = 8'h01; mode = 2'd1; iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (ovld_w[0] !== 1'b0 || ir_w[0] !== 1'b0) begin
      n_fail++; $display("FAIL rstbusy_handshake: got valid=%b ready=%b want 0/0", ovld_w[0], ir_w[0]);
    end
    n_tests++;
    if ({res_w[0], bo_w[0], ovf_w[0], z_w[0]} !== 11'd0) begin
      n_fail++; $display("FAIL rstbusy_outputs: got %h want 000", {res_w[0], bo_w[0], ovf_w[0], z_w[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (ir_w[0] !== 1'b1) begin n_fail++; $display("FAIL rstbusy_in_ready: got %b want 1", ir_w[0]); end
    repeat (4) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (ovld_w[0] !== 1'b0 || res_w[0] !== 8'h00) begin
        n_fail++; $display("FAIL rstbusy_stale: got valid=%b result=%h want 0/00", ovld_w[0], res_w[0]);
      end
    end
  endtask

  task automatic test_single_chunk;
    int lat;
    start_op(1, 8'h05, 8'h03, 2'd0, lat);
    n_tests++;
    if (lat != 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", lat); end
    n_tests++;
    if ({res_w[1], bo_w[1], ovf_w[1], z_w[1]} !== {8'h02, 3'b000}) begin
      n_fail++; $display("FAIL single_outputs: got %h want 010", {res_w[1], bo_w[1], ovf_w[1], z_w[1]});
    end
    release_op(1);
    n_tests++;
    if (ir_w[1] !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b want 1", ir_w[1]); end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_backpressure;
    test_isolation;
    test_random;
    test_reset_busy;
    test_single_chunk;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nbit_addsub_seq.md
Name: nbit_addsub_seq

Overview:
- Parametrised multi-mode add/subtract unit; successor to the team's combinational N-bit subtractor.
- Processes N-bit operands W bits per cycle, LSB chunk first, through a registered carry/borrow chain.
- Adds valid/ready handshakes, borrow/carry, overflow and zero flags, plus unsigned and signed saturating modes.
- Sits between operand-producing datapath logic and result consumers that can apply backpressure.

Parameters:
- N, 32, operand/result width; N >= 2.
- W, 8, chunk width processed per cycle; N % W == 0; W == N gives single-chunk operation.
- NCHUNK, N/W, derived localparam; not user-set.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand set valid
- in_ready  output  1  unit can accept operands
- a  input  N  operand A
- b  input  N  operand B
- mode  input  2  00 unsigned sub, 01 add, 10 unsigned saturating sub, 11 signed saturating sub
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts result
- result  output  N  final result
- borrow  output  1  sub modes: 1 when A < B unsigned (raw); add mode: carry out
- overflow  output  1  signed overflow of the raw operation; always 0 in mode 10
- zero  output  1  result == 0, evaluated after saturation

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the clk rising edge.
- Reset (rst_n low at an edge):
  - State becomes IDLE; chunk counter = 0; carry register = 0.
  - result = 0; borrow = overflow = zero = 0; out_valid = 0.
  - in_ready = 0 while rst_n is low.
- Reset mid-operation aborts the operation; no partial or stale result is ever presented.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: latch a, b and mode; set counter = 0; set carry-in to 1 for sub modes, 0 for add; go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each edge computes one chunk: a_chunk + (b_chunk, inverted for sub) + carry.
  - The chunk writes the result slice [k*W +: W] and updates the carry register; the counter increments.
- Finalisation, on the edge that processes chunk NCHUNK-1:
  - Flags are computed from the latched MSBs and the final carry.
  - borrow = ~carry_out for sub modes; borrow = carry_out for add.
  - Sub overflow = (a[N-1] != b[N-1]) & (r[N-1] != a[N-1]).
  - Add overflow = (a[N-1] == b[N-1]) & (r[N-1] != a[N-1]).
  - Mode 10: if borrow, result = 0; overflow forced to 0.
  - Mode 11: on overflow, result = 0x7F..F if a[N-1] == 0, else 0x80..0.
  - zero is computed from the final result.
  - Go to DONE.
- Latency: out_valid is high exactly NCHUNK edges after the accepting edge.
- DONE:
  - out_valid = 1; in_ready = 0.
  - result and flags hold stable while out_ready = 0.
  - An edge with out_ready = 1 moves to IDLE and drops out_valid.
  - in_ready rises the following cycle.
- Throughput: one operation per NCHUNK+2 cycles minimum. No overlap of operations.
- Input isolation: changes to a, b, mode or in_valid outside the accepting edge have no effect. in_valid during BUSY/DONE is ignored, not queued.
- Width rules:
  - All arithmetic is modulo 2^N.
  - Chunk carry is 1 bit; there is no carry out of the last chunk other than the flags.
  - result and flags change only on finalisation or reset.

Test Plan:
- Unsigned sub, N=8, W=4: A=0x05, B=0x03, mode 00 -> result 0x02, borrow 0, overflow 0, zero 0. out_valid exactly 2 edges after accept.
- Borrow and saturation: A=0x03, B=0x05, mode 00 -> 0xFE, borrow 1. Same operands, mode 10 -> 0x00, borrow 1, zero 1, overflow 0.
- Add:
  - A=0xF0, B=0x20, mode 01 -> 0x10, borrow (carry) 1, overflow 0.
  - A=0x70, B=0x10 -> 0x80, carry 0, overflow 1.
- Signed saturating sub:
  - A=0x80, B=0x01, mode 11 -> 0x80, overflow 1, borrow 0.
  - A=0x7F, B=0xFF -> 0x7F, overflow 1, borrow 1.
- Backpressure and isolation:
  - Hold out_ready = 0 for 5 cycles in DONE -> result and flags stable, in_ready 0.
  - Then out_ready = 1 -> IDLE; in_ready = 1 on the next cycle.
  - Changing a during BUSY does not alter the result.
- Reset and single-chunk regression:
  - rst_n low during BUSY -> out_valid 0, all outputs 0.
  - After release, in_ready = 1 and no stale result appears.
  - Rerun scenario 1 with W = N = 8 -> out_valid 1 edge after accept.
